// File: rtl/bch_syndrome_pkg.sv
// Shared definitions for the BCH syndrome receiver.
// Provides the framing state type and the elaboration-time GF(2^m) helpers:
//   bch_polynomial(m)      primitive polynomial for GF(2^m), including the x^m term
//   mul(m, a, b)           GF(2^m) product
//   lpow(m, e)             alpha^e
//   const_mul_matrix(m, j) columns of the M x M XOR matrix for "multiply by alpha^j"
//   mat_apply(mat, x)      applies such a matrix to an element
// Element representation: bit i holds the coefficient of alpha^i.
package bch_syndrome_pkg;

  localparam int unsigned MaxM = 16;
  localparam int unsigned IdxW = $clog2(MaxM);

  typedef logic [MaxM-1:0] gf_t;
  // Column c holds alpha^j * alpha^c, i.e. the image of basis element c.
  typedef gf_t [MaxM-1:0]  gf_mat_t;

  typedef enum logic [0:0] {StIdle, StBusy} frame_state_e;

  function automatic int unsigned bch_polynomial(int unsigned m);
    case (m)
      3:       return 32'h0000_000B;
      4:       return 32'h0000_0013;
      5:       return 32'h0000_0025;
      6:       return 32'h0000_0043;
      7:       return 32'h0000_0089;
      8:       return 32'h0000_011D;
      9:       return 32'h0000_0211;
      10:      return 32'h0000_0409;
      11:      return 32'h0000_0805;
      12:      return 32'h0000_1053;
      13:      return 32'h0000_201B;
      14:      return 32'h0000_4443;
      15:      return 32'h0000_8003;
      16:      return 32'h0001_100B;
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic gf_t field_mask(int unsigned m);
    return gf_t'((33'd1 << m) - 33'd1);
  endfunction

  // Multiply by alpha: shift up one degree and fold x^m back via the polynomial.
  function automatic gf_t xtime(int unsigned m, gf_t a);
    gf_t r;
    r = (a << 1) & field_mask(m);
    if (a[IdxW'(m - 1)]) r = r ^ (gf_t'(bch_polynomial(m)) & field_mask(m));
    return r;
  endfunction

  function automatic gf_t mul(int unsigned m, gf_t a, gf_t b);
    gf_t p;
    gf_t x;
    p = '0;
    x = a & field_mask(m);
    for (int i = 0; i < int'(MaxM); i++) begin
      if (i < int'(m) && b[IdxW'(i)]) p = p ^ x;
      x = xtime(m, x);
    end
    return p;
  endfunction

  function automatic gf_t lpow(int unsigned m, int unsigned e);
    gf_t r;
    int unsigned order;
    order = (32'd1 << m) - 32'd1;
    r = gf_t'(1);
    for (int unsigned i = 0; i < (e % order); i++) r = xtime(m, r);
    return r;
  endfunction

  function automatic gf_mat_t const_mul_matrix(int unsigned m, int unsigned j);
    gf_mat_t mat;
    mat = '0;
    for (int c = 0; c < int'(m); c++) mat[IdxW'(c)] = lpow(m, j + c);
    return mat;
  endfunction

  function automatic gf_t mat_apply(gf_mat_t mat, gf_t x);
    gf_t r;
    r = '0;
    for (int c = 0; c < int'(MaxM); c++) begin
      if (x[IdxW'(c)]) r = r ^ mat[IdxW'(c)];
    end
    return r;
  endfunction

endpackage

// File: rtl/bch_syndrome_lane.sv
// One Horner accumulator for syndrome S_J = r(alpha^J) over GF(2^M).
// Ports:
//   clk, reset     clock, async active-low reset
//   load           first bit of a frame: accumulator <= {0.., din}
//   shift          later bit: accumulator <= accumulator * alpha^J ^ din
//   din            serial received bit
//   acc_next       next-state value (includes the bit presented this cycle)
module bch_syndrome_lane
  import bch_syndrome_pkg::*;
#(
  parameter int unsigned M = 4,
  parameter int unsigned J = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic         din,
  output logic [M-1:0] acc_next
);

  localparam gf_mat_t Mat = const_mul_matrix(M, J);

  logic [M-1:0] acc_q;
  logic [M-1:0] scaled;

  // Constant multiply reduces to a fixed XOR network.
  assign scaled = M'(mat_apply(Mat, gf_t'(acc_q)));

  always_comb begin
    acc_next = acc_q;
    if (load) begin
      acc_next    = '0;
      acc_next[0] = din;
    end else if (shift) begin
      acc_next    = scaled;
      acc_next[0] = scaled[0] ^ din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) acc_q <= '0;
    else        acc_q <= acc_next;
  end

endmodule

// File: rtl/bch_syndrome.sv
// Serial BCH syndrome computer. Takes an N-bit codeword, highest degree first,
// evaluates odd syndromes S1..S(2T-1), captures the K message bits and flags errors.
// Ports:
//   clk, reset     clock, async active-low reset
//   din, din_en    serial bit and its qualifier (gaps allowed)
//   start          with din_en, marks degree N-1; aborts a frame in progress
//   syn            {S(2T-1), .., S3, S1}, M bits each, S1 in the LSBs
//   msg            captured message, first received bit in msg[K-1]
//   done           one-cycle pulse when syn/msg/err are updated
//   err            any syndrome nonzero, held with syn
//   busy           frame in progress
module bch_syndrome
  import bch_syndrome_pkg::*;
#(
  parameter int unsigned N = 15,
  parameter int unsigned K = 5,
  parameter int unsigned T = 3,
  localparam int unsigned M = $clog2(N + 2) - 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           din,
  input  logic           din_en,
  input  logic           start,
  output logic [T*M-1:0] syn,
  output logic [K-1:0]   msg,
  output logic           done,
  output logic           err,
  output logic           busy
);

  localparam int unsigned CntW = $clog2(N + 1);

  frame_state_e    state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic [K-1:0]    msg_sr_q, msg_sr_d;
  logic [T*M-1:0]  acc_next;
  logic [T*M-1:0]  syn_q;
  logic [K-1:0]    msg_q;
  logic            err_q, done_q;

  logic first, shift, last;

  // A start bit always restarts the frame, even mid-frame (abort without done).
  assign first = din_en && start;
  assign shift = din_en && !start && (state_q == StBusy);
  assign last  = shift && (count_q == CntW'(N - 1));

  for (genvar i = 0; i < int'(T); i++) begin : g_lane
    bch_syndrome_lane #(
      .M (M),
      .J (2 * i + 1)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .load     (first),
      .shift    (shift),
      .din      (din),
      .acc_next (acc_next[i*M +: M])
    );
  end

  // Framing FSM: state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Framing FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (first) state_d = StBusy;
      StBusy: if (last)  state_d = StIdle;
      default:           state_d = StIdle;
    endcase
  end

  // Framing FSM: outputs.
  always_comb begin
    busy = (state_q == StBusy);
  end

  // Bit counter and message capture; parity bits are not stored.
  always_comb begin
    count_d  = count_q;
    msg_sr_d = msg_sr_q;
    if (first) begin
      count_d     = CntW'(1);
      msg_sr_d    = '0;
      msg_sr_d[0] = din;
    end else if (shift) begin
      count_d = last ? '0 : count_q + CntW'(1);
      if (count_q < CntW'(K)) msg_sr_d = {msg_sr_q[K-2:0], din};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q  <= '0;
      msg_sr_q <= '0;
      syn_q    <= '0;
      msg_q    <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      msg_sr_q <= msg_sr_d;
      done_q   <= last;
      if (last) begin
        syn_q <= acc_next;
        msg_q <= msg_sr_d;
        err_q <= |acc_next;
      end
    end
  end

  assign syn  = syn_q;
  assign msg  = msg_q;
  assign err  = err_q;
  assign done = done_q;

endmodule

// File: doc/bch_syndrome.md
Name: bch_syndrome

Overview:
- Receive-side companion to the serial BCH encoder. Accepts the serial codeword stream: N bits, highest-degree coefficient first, K message bits followed by N-K parity bits.
- Computes odd syndromes S1, S3, …, S(2T-1) over GF(2^M) by bit-serial Horner evaluation.
- Captures the K message bits in parallel.
- Flags any nonzero syndrome so that a downstream error locator (Berlekamp/Chien) can start.

Parameters:
- N, 15, codeword length in bits (data + parity).
- K, 5, message length in bits.
- T, 3, correctable errors; sets the syndrome count.
- M, derived localparam $clog2(N+2)-1 (4 for defaults); GF field width, not user-set.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- din  in  1  serial received bit.
- din_en  in  1  din is valid this cycle; bits are accepted only when high.
- start  in  1  qualified by din_en; marks the first bit (degree N-1) of a codeword.
- syn  out  T*M  syndromes; S1 in [M-1:0], S3 next, S(2T-1) in MSBs.
- msg  out  K  captured message bits; the first received bit is msg[K-1].
- done  out  1  one-cycle pulse: syn/msg/err updated for the completed codeword.
- err  out  1  high when any syndrome is nonzero; held with syn.
- busy  out  1  high while a frame is in progress (bits 1..N-1 still pending).

Behaviour:
- Reset (async, reset=0): all accumulators, syn, msg zero; count=0; done=0, err=0, busy=0. Takes effect immediately; release is synchronous to clk.
- Accept = din_en && (busy || start). Bits with din_en low are ignored and all state holds (gaps allowed anywhere in a frame).
- Start bit: accumulators load their first value, S_j <= {M-1 zeros, din}. msg shift register loads din, count <= 1, busy <= 1.
- Subsequent accepted bit: S_j <= (S_j * alpha^j) ^ din, using a constant GF multiply over the primitive polynomial bch_polynomial(M). count <= count+1.
- msg: shift-left capture while count < K only; parity bits are not stored.
- On the accepted bit with count == N-1:
  - Next edge: syn <= final accumulator values (this includes the current bit), msg <= final shift value.
  - err <= |final syndromes; done <= 1 for one cycle; busy <= 0; count <= 0.
  - Latency is 1 cycle from the last bit to done.
- syn/msg/err hold until the next done. They are not cleared at a new start.
- Back-to-back frames: start may coincide with the cycle after the last bit, i.e. the same edge on which done asserts. No bubble is required.
- start while busy: abort the current frame with no done, then restart with this bit as degree N-1. syn/msg/err keep their previous values.
- start with din_en low: ignored.
- Element representation: bit i = coefficient of alpha^i. Primitive polynomial for M=4 is x^4+x+1.

Decomposition:
- Shared include bch.vh supplies:
  - bch_polynomial(M), mul(m,a,b), lpow(m,e).
  - A new helper, const_mul_matrix(m,j), which builds the M×M XOR matrix for multiply by alpha^j at elaboration.
- Sub-module bch_syndrome_lane (parameters M, J): one Horner accumulator with load/shift/hold controls. Instantiated T times via generate with J=2i+1.
- Top-level module holds only the counter, framing FSM (IDLE/BUSY), msg capture and output registers.

Test Plan:
- All-zero frame, N=15 bits, din_en=1 continuously → done exactly 1 cycle after bit 15; syn=0, err=0, msg=5'b00000.
- Single 1 as the last bit (degree 0) → S1=S3=S5=4'b0001; err=1.
- Single 1 as the 14th bit (degree 1) → S1=4'b0010, S3=4'b1000, S5=4'b0110.
- Single 1 as the first bit (degree 14) → S1=4'b1001, S3=4'b1111, S5=4'b0111; msg=5'b10000.
- Loopback from the serial BCH encoder:
  - Random messages with 0 injected errors → err=0, msg=message.
  - Insert din_en gaps of 1–3 cycles, and run back-to-back frames → identical results and one done per frame.
- Control corner cases:
  - reset driven low at bit 7 → outputs zero immediately and no done.
  - start reasserted at bit 9 of a frame → no done for the aborted frame; the next done arrives 15 accepted bits after the restart, with the correct syndromes.
